// File: rtl/ecc_err_telemetry.sv
// ECC error telemetry: per-class saturating totals, windowed SBE rate alarm FSM and event FIFO.
// Event FIFO is compiled in only when ECC_TELEM_EVT_FIFO_EN is defined; otherwise evt_* outputs are tied to 0.
module ecc_err_telemetry #(
  parameter int CNT_WIDTH     = 16,
  parameter int WINDOW_CYCLES = 1024,
  parameter int SBE_THRESH    = 8,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [7:0]           in_syndrome,
  input  logic                 in_sbe,
  input  logic                 in_dbe,
  input  logic                 in_parity,
  input  logic                 clr_cnt,
  input  logic                 clr_alarm,
  output logic [CNT_WIDTH-1:0] sbe_total,
  output logic [CNT_WIDTH-1:0] dbe_total,
  output logic [CNT_WIDTH-1:0] par_total,
  output logic [CNT_WIDTH-1:0] win_sbe,
  output logic                 win_done,
  output logic [1:0]           alarm_state,
  output logic                 alarm_irq,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [9:0]           evt_data,
  output logic                 evt_ovf
);

  typedef enum logic [1:0] {EVT_NONE = 2'b00, EVT_SBE = 2'b01, EVT_DBE = 2'b10, EVT_PAR = 2'b11} evt_e;
  typedef enum logic [1:0] {ST_NORMAL = 2'b00, ST_WARN = 2'b01, ST_CRIT = 2'b10} alarm_e;

  localparam int WW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WW-1:0]        WIN_LAST = WW'(WINDOW_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] THRESH   = CNT_WIDTH'(SBE_THRESH);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  evt_e evt_type;
  logic is_sbe, is_dbe, is_par;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    evt_type = EVT_NONE;
    if (in_valid) begin
      if (in_dbe)                    evt_type = EVT_DBE;
      else if (in_sbe && in_parity)  evt_type = EVT_PAR;
      else if (in_sbe)               evt_type = EVT_SBE;
    end
  end

  assign is_sbe = (evt_type == EVT_SBE);
  assign is_dbe = (evt_type == EVT_DBE);
  assign is_par = (evt_type == EVT_PAR);

  logic [CNT_WIDTH-1:0] sbe_total_q, sbe_total_d, dbe_total_q, dbe_total_d, par_total_q, par_total_d;
  logic [CNT_WIDTH-1:0] win_cnt_sbe_q, win_cnt_sbe_d, win_sbe_q, win_sbe_d, win_sbe_now;
  logic [WW-1:0]        win_cyc_q, win_cyc_d;
  logic                 win_done_d, win_done_q, win_close;

  // Window SBE value including a same-cycle event; this is what a closing window reports.
  assign win_sbe_now = is_sbe ? sat_inc(win_cnt_sbe_q) : win_cnt_sbe_q;
  assign win_close   = (win_cyc_q == WIN_LAST) && !clr_cnt;

  always_comb begin
    sbe_total_d   = sbe_total_q;
    dbe_total_d   = dbe_total_q;
    par_total_d   = par_total_q;
    win_cnt_sbe_d = win_sbe_now;
    win_sbe_d     = win_sbe_q;
    win_cyc_d     = win_cyc_q + WW'(1);
    win_done_d    = 1'b0;
    if (clr_cnt) begin
      sbe_total_d   = '0;
      dbe_total_d   = '0;
      par_total_d   = '0;
      win_cnt_sbe_d = '0;
      win_cyc_d     = '0;
    end else begin
      if (is_sbe) sbe_total_d = sat_inc(sbe_total_q);
      if (is_dbe) dbe_total_d = sat_inc(dbe_total_q);
      if (is_par) par_total_d = sat_inc(par_total_q);
      if (win_close) begin
        win_sbe_d     = win_sbe_now;
        win_done_d    = 1'b1;
        win_cnt_sbe_d = '0;
        win_cyc_d     = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sbe_total_q   <= '0;
      dbe_total_q   <= '0;
      par_total_q   <= '0;
      win_cnt_sbe_q <= '0;
      win_sbe_q     <= '0;
      win_cyc_q     <= '0;
      win_done_q    <= 1'b0;
    end else begin
      sbe_total_q   <= sbe_total_d;
      dbe_total_q   <= dbe_total_d;
      par_total_q   <= par_total_d;
      win_cnt_sbe_q <= win_cnt_sbe_d;
      win_sbe_q     <= win_sbe_d;
      win_cyc_q     <= win_cyc_d;
      win_done_q    <= win_done_d;
    end
  end

  alarm_e alarm_q;
  logic   alarm_irq_q;
  logic   win_hot;

  assign win_hot = (win_sbe_now >= THRESH);

  // DBE beats clr_alarm, which beats window-close evaluation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alarm_q     <= ST_NORMAL;
      alarm_irq_q <= 1'b0;
    end else begin
      alarm_irq_q <= 1'b0;
      if (is_dbe) begin
        alarm_q     <= ST_CRIT;
        alarm_irq_q <= (alarm_q != ST_CRIT);
      end else if (clr_alarm) begin
        alarm_q <= ST_NORMAL;
      end else if (win_close) begin
        case (alarm_q)
          ST_NORMAL: if (win_hot) begin
            alarm_q     <= ST_WARN;
            alarm_irq_q <= 1'b1;
          end
          ST_WARN: if (win_hot) begin
            alarm_q     <= ST_CRIT;
            alarm_irq_q <= 1'b1;
          end else begin
            alarm_q <= ST_NORMAL;
          end
          default: alarm_q <= alarm_q;
        endcase
      end
    end
  end

  assign sbe_total   = sbe_total_q;
  assign dbe_total   = dbe_total_q;
  assign par_total   = par_total_q;
  assign win_sbe     = win_sbe_q;
  assign win_done    = win_done_q;
  assign alarm_state = alarm_q;
  assign alarm_irq   = alarm_irq_q;

`ifdef ECC_TELEM_EVT_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW = AW + 1;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic          ovf_q, empty, full, push, pop, push_ok, drop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push    = (evt_type != EVT_NONE);
  assign pop     = !empty && evt_ready;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      if (clr_cnt)   ovf_q <= 1'b0;
      else if (drop) ovf_q <= 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= {evt_type, in_syndrome};
  end

  assign evt_valid = !empty;
  assign evt_data  = mem[rd_ptr_q[AW-1:0]];
  assign evt_ovf   = ovf_q;
`else
  logic unused_evt;
  assign unused_evt = ^{evt_ready, in_syndrome};
  assign evt_valid  = 1'b0;
  assign evt_data   = '0;
  assign evt_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_err_telemetry.sv
// Directed self-checking bench for ecc_err_telemetry; FIFO expectations follow ECC_TELEM_EVT_FIFO_EN.
module tb_ecc_err_telemetry;

  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_sbe, in_dbe, in_parity, clr_cnt, clr_alarm, evt_ready;
  logic [7:0]    in_syndrome;
  logic [CW-1:0] sbe_total, dbe_total, par_total, win_sbe;
  logic          win_done, alarm_irq, evt_valid, evt_ovf;
  logic [1:0]    alarm_state;
  logic [9:0]    evt_data;

  int n_checks = 0;
  int n_pass   = 0;

  ecc_err_telemetry #(.CNT_WIDTH(CW), .WINDOW_CYCLES(32), .SBE_THRESH(8), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_syndrome(in_syndrome),
    .in_sbe(in_sbe), .in_dbe(in_dbe), .in_parity(in_parity),
    .clr_cnt(clr_cnt), .clr_alarm(clr_alarm),
    .sbe_total(sbe_total), .dbe_total(dbe_total), .par_total(par_total),
    .win_sbe(win_sbe), .win_done(win_done), .alarm_state(alarm_state), .alarm_irq(alarm_irq),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data), .evt_ovf(evt_ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic s, input logic d, input logic p, input logic [7:0] syn);
    in_valid    = v;
    in_sbe      = s;
    in_dbe      = d;
    in_parity   = p;
    in_syndrome = syn;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic wait_win(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (win_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Head of FIFO: real entry when the FIFO is built, tied-off zero otherwise.
  task automatic check_head(input string tag, input logic [9:0] exp_data);
`ifdef ECC_TELEM_EVT_FIFO_EN
    check({tag, "_valid"}, evt_valid, 1);
    check({tag, "_data"}, evt_data, exp_data);
`else
    check({tag, "_valid"}, evt_valid, 0);
    check({tag, "_data"}, evt_data, 0 & exp_data);
`endif
  endtask

  task automatic check_ovf(input string tag, input logic exp_ovf);
`ifdef ECC_TELEM_EVT_FIFO_EN
    check(tag, evt_ovf, exp_ovf);
`else
    check(tag, evt_ovf, 0 & exp_ovf);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [9:0] exp_drain [8];

    rst_n = 1'b0; clr_cnt = 1'b0; clr_alarm = 1'b0; evt_ready = 1'b0;
    idle();
    step(); step();
    check("rst_sbe_total", sbe_total, 0);
    check("rst_win_sbe", win_sbe, 0);
    check("rst_alarm", alarm_state, 2'b00);
    check("rst_irq", alarm_irq, 0);
    check("rst_win_done", win_done, 0);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_ovf", evt_ovf, 0);
    rst_n = 1'b1;

    // Three SBE events, syndrome 07; valid and count one cycle after the first
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h07);
    step();
    check("lat_sbe_total", sbe_total, 1);
`ifdef ECC_TELEM_EVT_FIFO_EN
    check("lat_evt_valid", evt_valid, 1);
`else
    check("lat_evt_valid", evt_valid, 0);
`endif
    step(); step();
    idle();
    check("three_sbe_total", sbe_total, 3);
    check("three_dbe_total", dbe_total, 0);
    evt_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_head($sformatf("three_head%0d", i), 10'h107);
      step();
    end
    check("three_drained", evt_valid, 0);

    // Two consecutive hot windows: WARN then CRITICAL
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    check("clr_sbe_total", sbe_total, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h07);
    repeat (8) step();
    idle();
    wait_win(ok);
    check("win1_seen", ok, 1);
    check("win1_win_sbe", win_sbe, 8);
    check("win1_alarm", alarm_state, 2'b01);
    check("win1_irq", alarm_irq, 1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h07);
    step();
    check("win1_irq_pulse", alarm_irq, 0);
    check("win1_done_pulse", win_done, 0);
    repeat (7) step();
    idle();
    wait_win(ok);
    check("win2_seen", ok, 1);
    check("win2_win_sbe", win_sbe, 8);
    check("win2_alarm", alarm_state, 2'b10);
    check("win2_irq", alarm_irq, 1);
    check("win2_sbe_total", sbe_total, 16);

    // Event on every cycle of a window: window count and total saturate at 31
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h07);
    for (int i = 0; i < 32; i++) begin
      step();
      if (i == 30) check("sat_no_close_early", win_done, 0);
    end
    idle();
    check("sat_win_done", win_done, 1);
    check("sat_win_sbe", win_sbe, 31);
    check("sat_sbe_total", sbe_total, 31);
    check("sat_alarm_held", alarm_state, 2'b10);
    check("sat_no_irq", alarm_irq, 0);

    clr_alarm = 1'b1; step(); clr_alarm = 1'b0;
    check("clr_alarm_state", alarm_state, 2'b00);
    check("clr_alarm_no_irq", alarm_irq, 0);

    // DBE with same-cycle clr_alarm: DBE wins
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h03);
    clr_alarm = 1'b1;
    step();
    clr_alarm = 1'b0; idle();
    check("dbe_alarm", alarm_state, 2'b10);
    check("dbe_irq", alarm_irq, 1);
    check("dbe_total", dbe_total, 1);
    check_head("dbe_head", 10'h203);
    evt_ready = 1'b0;
    step();
    check("dbe_irq_pulse", alarm_irq, 0);
    evt_ready = 1'b1; step(); evt_ready = 1'b0;

    // Overflow: nine parity events into an 8-deep FIFO with no consumer
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h20 + 8'(i));
      step();
      if (i == 7) check_ovf("ovf_not_yet", 1'b0);
    end
    check_ovf("ovf_set", 1'b1);
    check_head("ovf_head", 10'h320);
    check("ovf_par_total", par_total, 9);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h30);
    evt_ready = 1'b1;
    step();
    idle();
    exp_drain = '{10'h321, 10'h322, 10'h323, 10'h324, 10'h325, 10'h326, 10'h327, 10'h330};
    for (int i = 0; i < 8; i++) begin
      check_head($sformatf("drain%0d", i), exp_drain[i]);
      step();
    end
    check("drain_empty", evt_valid, 0);
    check_ovf("ovf_sticky", 1'b1);
    check("drain_par_total", par_total, 10);

    // Parity event together with clr_cnt: not counted, still pushed, overflow cleared
    evt_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h10);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0; idle();
    check("clrcnt_par_total", par_total, 0);
    check("clrcnt_dbe_total", dbe_total, 0);
    check("clrcnt_win_sbe_kept", win_sbe, 31);
    check_ovf("clrcnt_ovf", 1'b0);
    check_head("clrcnt_head", 10'h310);

    // Flags without in_valid are ignored
    clr_alarm = 1'b1; step(); clr_alarm = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'hff);
    step();
    idle();
    check("novalid_dbe_total", dbe_total, 0);
    check("novalid_sbe_total", sbe_total, 0);
    check("novalid_alarm", alarm_state, 2'b00);
    check_head("novalid_head", 10'h310);

    // Reset mid-window discards counts and FIFO contents
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h07);
    step(); step();
    idle();
    check("pre_rst_sbe_total", sbe_total, 2);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check("midrst_sbe_total", sbe_total, 0);
    check("midrst_win_sbe", win_sbe, 0);
    check("midrst_alarm", alarm_state, 2'b00);
    check("midrst_evt_valid", evt_valid, 0);
    check("midrst_evt_ovf", evt_ovf, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ecc_err_telemetry.md
ECC_ERR_TELEMETRY -- requirements
Module: ecc_err_telemetry

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- CNT_WIDTH, 16, width of every error counter.
- WINDOW_CYCLES, 1024, length in clk cycles of one rate-measurement window.
- SBE_THRESH, 8, SBE count per window that triggers WARN.
- FIFO_DEPTH, 8, event FIFO entries (power of 2).
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock.
- rst_n, in, 1, reset, synchronous, active-low.
- in_valid, in, 1, telemetry qualifier (ECC read-data valid, same cycle as flags).
- in_syndrome, in, 8, ECC syndrome.
- in_sbe, in, 1, single-bit error.
- in_dbe, in, 1, double-bit error.
- in_parity, in, 1, error in a check bit.
- clr_cnt, in, 1, clear counters and overflow flag.
- clr_alarm, in, 1, return alarm FSM to NORMAL.
- sbe_total, out, CNT_WIDTH, saturating data-SBE count.
- dbe_total, out, CNT_WIDTH, saturating DBE count.
- par_total, out, CNT_WIDTH, saturating check-bit error count.
- win_sbe, out, CNT_WIDTH, data-SBE count of the last completed window.
- win_done, out, 1, one-cycle pulse when win_sbe updates.
- alarm_state, out, 2, 00 NORMAL, 01 WARN, 10 CRITICAL.
- alarm_irq, out, 1, one-cycle pulse on any alarm escalation.
- evt_valid, out, 1, event FIFO non-empty.
- evt_ready, in, 1, consumer accepts the head event.
- evt_data, out, 10, {type[1:0], syndrome[7:0]}; type 01 SBE, 10 DBE, 11 PARITY.
- evt_ovf, out, 1, sticky: an event was dropped.

Function
REQ-003 An event occurs only in a cycle with in_valid=1; flags are ignored when in_valid=0.
REQ-004 Classification priority: in_dbe gives DBE; else in_sbe with in_parity gives PARITY; else in_sbe gives SBE; else no event.
REQ-005 Each class increments its own total by 1 in the cycle after the event. Totals saturate at all-ones, with no wrap.
REQ-006 The window counter runs from 0 to WINDOW_CYCLES-1 and wraps. On the wrap cycle:
- the window SBE count, including an event in that same cycle, is copied to win_sbe;
- win_done pulses the next cycle;
- the window count restarts at 0.
REQ-007 The window SBE count saturates at all-ones.
REQ-008 clr_cnt=1 zeroes all totals, the window SBE count, the window counter and evt_ovf. clr_cnt wins over a same-cycle event, which is not counted but is still pushed to the FIFO. win_sbe is unaffected.
REQ-009 Alarm FSM transitions:
- NORMAL to WARN on window close with window SBE >= SBE_THRESH.
- Any state to CRITICAL on a DBE event.
- WARN to CRITICAL on a second consecutive window close with window SBE >= SBE_THRESH.
- WARN to NORMAL on window close with window SBE < SBE_THRESH.
- CRITICAL is held until clr_alarm.
REQ-010 clr_alarm forces NORMAL, but a same-cycle DBE event wins and gives CRITICAL.
REQ-011 alarm_irq pulses for one cycle, registered, on every transition to a higher-severity state. There is no pulse on de-escalation.
REQ-012 FIFO push rules:
- Every event pushes {type, syndrome}.
- A push onto a full FIFO is dropped and sets evt_ovf.
- A simultaneous pop and push on a full FIFO accepts the push, with no overflow.
REQ-013 FIFO pop occurs when evt_valid and evt_ready are both 1. evt_data shows the head entry combinationally from storage. evt_ready while empty has no effect.
REQ-014 Latency:
- an event appears on evt_valid one cycle after it occurs, into an empty FIFO;
- counters update one cycle after the event.

Reset
REQ-015 When rst_n=0 at a clk edge, every register resets:
- all totals, win_sbe, the window count and the window counter go to 0;
- alarm_state goes to NORMAL;
- win_done, alarm_irq, evt_valid and evt_ovf go to 0;
- FIFO pointers go to empty.
REQ-016 A reset in the middle of a window discards the partial count, and FIFO contents are lost.

Configuration
REQ-017 The event FIFO is controlled by macro ECC_TELEM_EVT_FIFO_EN.
- Defined: the FIFO and REQ-012/013 behaviour are present.
- Undefined: no FIFO storage; evt_valid, evt_data and evt_ovf are tied to 0; evt_ready is ignored; all counter and alarm behaviour is unchanged.

Verification
REQ-018 Reset, then 3 SBE events (syndrome 8'h07) -> sbe_total=3; FIFO holds three entries of 10'h107; evt_valid=1 one cycle after the first event.
REQ-019 8 SBE events in window 1, then 8 in window 2 -> WARN with alarm_irq at the first close; CRITICAL with alarm_irq at the second close; win_sbe=8 both times.
REQ-020 One DBE (syndrome 8'h03) while NORMAL, with clr_alarm in the same cycle -> CRITICAL, alarm_irq=1, dbe_total=1, FIFO entry 10'h203.
REQ-021 evt_ready=0 and 9 events with FIFO_DEPTH=8 -> 8 entries held, evt_ovf=1; a pop and push together while full -> no entry lost.
REQ-022 An event with in_sbe=1 and in_parity=1 (syndrome 8'h10) in the same cycle as clr_cnt -> par_total stays 0, evt_ovf cleared, FIFO entry 10'h310 pushed.
